// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time over req/ack,
// holds the fetched word for the controller and computes the next PC on accept.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pc_out_r;
  logic [31:0] instruction_r;
  logic        valid_r;
  logic        imem_req_r;

  logic [31:0] pc4_s;
  logic [31:0] branch_disp_s;
  logic [31:0] next_pc_s;
  logic        accept_s;
  logic        unused_jr_lsb_s;

  assign pc4_s           = pc_out_r + 32'd4;
  assign branch_disp_s   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign accept_s        = (state_r == HOLD) && valid_r && !stall;
  assign unused_jr_lsb_s = ^jr_target[1:0];

  // Next-PC select for the presented word: jr > jump > branch > sequential.
  always_comb begin
    next_pc_s = pc4_s;
    if (jr) begin
      next_pc_s = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc_s = {pc4_s[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc_s = pc4_s + branch_disp_s;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Fetch FSM: IDLE -> REQ (wait for ack) -> HOLD (wait for accept) -> REQ.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= IDLE;
      pc_r          <= {RESET_PC[31:2], 2'b00};
      imem_req_r    <= 1'b0;
      valid_r       <= 1'b0;
      instruction_r <= 32'h0000_0000;
      pc_out_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= REQ;
          imem_req_r <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instruction_r <= imem_data;
            pc_out_r      <= pc_r;
            valid_r       <= 1'b1;
            imem_req_r    <= 1'b0;
            state_r       <= HOLD;
          end else begin
            imem_req_r <= 1'b1;
            state_r    <= REQ;
          end
        end
        HOLD: begin
          // Redirect inputs only matter on this edge; no request is in flight here.
          if (accept_s) begin
            pc_r       <= next_pc_s;
            valid_r    <= 1'b0;
            imem_req_r <= 1'b1;
            state_r    <= REQ;
          end else begin
            imem_req_r <= 1'b0;
            state_r    <= HOLD;
          end
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
          valid_r    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = {pc_r[31:2], 2'b00};
  assign imem_req    = imem_req_r;
  assign instruction = instruction_r;
  assign pc_out      = pc_out_r;
  assign valid       = valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency, stalls and redirects
// checked against a PC-sequence reference model.
module tb_fetch_unit;

  logic        CLOCK;
  logic        RESET_N;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;

  // second instance: wrap-around reset address, always-ack memory
  logic [31:0] imem_addr_w;
  logic        imem_req_w;
  logic        imem_ack_w;
  logic [31:0] imem_data_w;
  logic [31:0] instruction_w;
  logic [31:0] pc_out_w;
  logic        valid_w;
  logic        zero_b;
  logic [15:0] zero16;
  logic [25:0] zero26;
  logic [31:0] zero32;

  assign imem_ack_w = imem_req_w;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .instruction(instruction), .pc_out(pc_out), .valid(valid), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_addr(imem_addr_w), .imem_req(imem_req_w), .imem_ack(imem_ack_w), .imem_data(imem_data_w),
    .instruction(instruction_w), .pc_out(pc_out_w), .valid(valid_w), .stall(zero_b),
    .branch_taken(zero_b), .branch_offset(zero16),
    .jump(zero_b), .jump_index(zero26), .jr(zero_b), .jr_target(zero32)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference next-PC rule, plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit jr_b, input logic [31:0] jt,
                                           input bit j_b, input logic [25:0] idx,
                                           input bit br_b, input logic [15:0] off);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jr_b) return jt & 32'hFFFF_FFFC;
    if (j_b)  return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
    if (br_b) return seq + (32'($signed(off)) * 32'd4);
    return seq;
  endfunction

  // directed prologue: accept k uses these redirects
  bit          d_jr  [0:9] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 0};
  bit          d_jmp [0:9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  bit          d_br  [0:9] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
  logic [31:0] d_jt  [0:9] = '{32'h0, 32'h0, 32'h0, 32'h0000_0100, 32'h0, 32'h9000_0010,
                               32'h0, 32'h0000_2003, 32'hFFFF_FFFF, 32'h0};
  logic [25:0] d_idx [0:9] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h40, 26'h40, 26'h0, 26'h0};
  logic [15:0] d_off [0:9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFC, 16'h0, 16'h8, 16'h8, 16'h0, 16'h0};
  logic [31:0] dir_pc[0:10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'hF4, 32'h9000_0010,
                                32'h9000_0100, 32'h2000, 32'hFFFF_FFFC, 32'h0};

  logic [31:0] exp_q[$];
  logic [31:0] w_q[$];
  logic [31:0] cur_pc_m;
  bit          run_en;
  int          words_seen = 0;

  // memory responder: random latency, address stability, spurious acks outside REQ
  bit          rsp_prev_req;
  int          rsp_cnt, rsp_want, req_idx = 0;
  logic [31:0] held_addr;
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      imem_ack     = 1'b0;
      rsp_prev_req = 1'b0;
    end else begin
      if (imem_req) begin
        if (!rsp_prev_req) begin
          rsp_cnt   = 0;
          rsp_want  = (req_idx == 1) ? 3 : ((req_idx < 8) ? 0 : $urandom_range(0, 3));
          held_addr = imem_addr;
          req_idx++;
        end else begin
          chk("addr_stable", imem_addr, held_addr);
        end
        if (rsp_cnt == rsp_want) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
        end else begin
          imem_ack  = 1'b0;
          imem_data = $urandom;
        end
        rsp_cnt++;
      end else begin
        imem_ack  = ($urandom_range(0, 3) == 0);
        imem_data = $urandom;
      end
      rsp_prev_req = imem_req;
    end
  end

  // controller driver: stalls, redirects, pushes expected next PC on accept
  bit          drv_prev_v, pend_chk;
  logic [31:0] pend_addr, nxt;
  int          acc_k = 0, hold_cnt, stall_want, r;
  always @(negedge CLOCK) begin
    if (!RESET_N || !run_en) begin
      stall = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      drv_prev_v = 1'b0; pend_chk = 1'b0;
    end else begin
      if (pend_chk) begin
        chk("next_req", imem_req, 32'd1);
        chk("next_addr", imem_addr, pend_addr);
        pend_chk = 1'b0;
      end
      jr = 1'($urandom); jump = 1'($urandom); branch_taken = 1'($urandom);
      jr_target = $urandom; jump_index = 26'($urandom); branch_offset = 16'($urandom);
      stall = 1'($urandom);
      if (valid) begin
        if (!drv_prev_v) begin
          hold_cnt   = 0;
          stall_want = (acc_k < 10) ? ((acc_k == 2) ? 4 : 0) : $urandom_range(0, 2);
        end
        stall = (hold_cnt < stall_want);
        hold_cnt++;
        if (!stall) begin
          if (acc_k < 10) begin
            jr = d_jr[acc_k]; jump = d_jmp[acc_k]; branch_taken = d_br[acc_k];
            jr_target = d_jt[acc_k]; jump_index = d_idx[acc_k]; branch_offset = d_off[acc_k];
          end else begin
            r = $urandom_range(0, 7);
            jr = (r == 0); jump = (r <= 2); branch_taken = (r <= 4);
          end
          nxt = ref_next(cur_pc_m, jr, jr_target, jump, jump_index, branch_taken, branch_offset);
          exp_q.push_back(nxt);
          cur_pc_m  = nxt;
          pend_addr = nxt;
          pend_chk  = 1'b1;
          acc_k++;
        end
      end
      drv_prev_v = valid;
    end
  end

  // monitor: pops the expected PC when a new word appears, checks it every held cycle
  bit          mon_prev_v;
  logic [31:0] mon_exp;
  always @(negedge CLOCK) begin
    if (!RESET_N || !run_en) begin
      mon_prev_v = 1'b0;
    end else begin
      if (valid) begin
        if (!mon_prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_word: actual pc_out %h required no word", pc_out);
          end else begin
            mon_exp = exp_q.pop_front();
          end
          if (words_seen < 11) chk("directed_pc", pc_out, dir_pc[words_seen]);
          words_seen++;
        end
        chk("pc_out", pc_out, mon_exp);
        chk("instruction", instruction, mem_word(mon_exp));
        chk("req_low_in_hold", imem_req, 32'd0);
      end
      mon_prev_v = valid;
    end
  end

  bit w_prev;
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      w_prev = 1'b0;
    end else begin
      if (valid_w && !w_prev) w_q.push_back(pc_out_w);
      w_prev = valid_w;
    end
  end

  int cyc, base;
  initial begin
    CLOCK = 1'b0; RESET_N = 1'b0; run_en = 1'b0;
    stall = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = 32'h0; jump_index = 26'h0; branch_offset = 16'h0;
    imem_ack = 1'b0; imem_data = 32'h0;
    zero_b = 1'b0; zero16 = 16'h0; zero26 = 26'h0; zero32 = 32'h0; imem_data_w = 32'h0;
    repeat (3) @(negedge CLOCK);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", valid, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    cur_pc_m = 32'h0;
    exp_q.push_back(32'h0);
    run_en  = 1'b1;
    RESET_N = 1'b1;
    #1 chk("idle_no_req", imem_req, 32'd0);
    @(negedge CLOCK);
    chk("first_req", imem_req, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    cyc = 0;
    while (words_seen < 40 && cyc < 3000) begin @(negedge CLOCK); cyc++; end
    if (words_seen < 40) begin
      n_checks++; n_err++;
      $display("FAIL timeout_phase1: actual %0d words required 40", words_seen);
    end

    cyc = 0;
    while (!imem_req && cyc < 50) begin @(negedge CLOCK); cyc++; end
    chk("req_before_async_rst", imem_req, 32'd1);
    #2 RESET_N = 1'b0;
    run_en = 1'b0;
    #1;
    chk("async_rst_req", imem_req, 32'd0);
    chk("async_rst_valid", valid, 32'd0);
    repeat (2) @(negedge CLOCK);
    exp_q.delete();
    cur_pc_m = 32'h0;
    exp_q.push_back(32'h0);
    base    = words_seen;
    run_en  = 1'b1;
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("refetch_req", imem_req, 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);

    cyc = 0;
    while (words_seen < base + 20 && cyc < 2000) begin @(negedge CLOCK); cyc++; end
    if (words_seen < base + 20) begin
      n_checks++; n_err++;
      $display("FAIL timeout_phase2: actual %0d words required %0d", words_seen, base + 20);
    end

    if (w_q.size() >= 2) begin
      chk("wrap_first", w_q[0], 32'hFFFF_FFFC);
      chk("wrap_second", w_q[1], 32'h0);
    end else begin
      n_checks++; n_err++;
      $display("FAIL wrap_words: actual %0d words required 2", w_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
